// File: rtl/data_mem_banked.sv
// Banked word memory: CPU read/write port with byte enables and range error,
// an independent never-stalled VGA byte-read port, and a one-bank zero-fill engine.
module data_mem_banked #(
  parameter int NUM_BANKS = 3,
  parameter int BANK_AW   = 14,
  parameter int DATA_W    = 32,
  parameter int PIX_W     = 8,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_wren,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [31:0]         cpu_addr,
  input  logic [DATA_W-1:0]   data_cpu,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   out_data_cpu,
  output logic                cpu_rvalid,
  output logic                cpu_err,
  input  logic                vga_rd,
  input  logic [31:0]         vga_addr,
  output logic [PIX_W-1:0]    out_data_vga,
  output logic                vga_rvalid,
  input  logic                clr_start,
  input  logic [BANK_W-1:0]   clr_bank,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int          LANES      = DATA_W / 8;
  localparam int          LANE_SH    = $clog2(LANES);
  localparam int          LANE_W     = (LANE_SH > 0) ? LANE_SH : 1;
  localparam int          IDX_W      = BANK_W + BANK_AW;
  localparam int unsigned DEPTH      = NUM_BANKS * (2 ** BANK_AW);
  localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [BANK_W-1:0]   clr_bank_q;
  logic [BANK_AW-1:0]  clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                cpu_acc, cpu_wr_go, cpu_in_range;
  logic [IDX_W-1:0]    cpu_idx;
  logic [31:0]         vga_word;
  logic                vga_in_range;
  logic [IDX_W-1:0]    vga_idx;
  logic [LANE_W-1:0]   vga_lane;
  logic                clr_go, clr_last;

  // Bank k occupies words k*2^BANK_AW.., so the word address is the flat index.
  assign cpu_in_range = cpu_addr < 32'(DEPTH);
  assign cpu_idx      = cpu_addr[IDX_W-1:0];
  assign cpu_acc      = cpu_req && cpu_ready;
  assign cpu_wr_go    = cpu_acc && cpu_wren && cpu_in_range;

  assign vga_word     = vga_addr >> LANE_SH;
  assign vga_in_range = vga_word < 32'(DEPTH);
  assign vga_idx      = vga_word[IDX_W-1:0];
  assign vga_lane     = (LANES > 1) ? vga_addr[LANE_W-1:0] : '0;

  assign clr_go   = (state == IDLE) && clr_start && ({1'b0, clr_bank} < BANK_LIMIT);
  assign clr_last = (clr_cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_go)   state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    clr_busy  = 1'b0;
    case (state)
      IDLE:    cpu_ready = 1'b1;
      CLEAR:   clr_busy  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_bank_q <= '0;
      clr_cnt    <= '0;
      clr_done   <= 1'b0;
    end else begin
      clr_done <= (state == CLEAR) && clr_last;
      if (clr_go) begin
        clr_bank_q <= clr_bank;
        clr_cnt    <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; a cleared bank comes only from the clear engine.
  // CPU writes and clear writes never share an edge: the CPU is held off while clearing.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[{clr_bank_q, clr_cnt}] <= '0;
    end else if (cpu_wr_go) begin
      for (int i = 0; i < LANES; i++) begin
        if (cpu_be[i]) mem[cpu_idx][8*i +: 8] <= data_cpu[8*i +: 8];
      end
    end
  end

  // Read ports sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_cpu <= '0;
      cpu_rvalid   <= 1'b0;
      cpu_err      <= 1'b0;
      out_data_vga <= '0;
      vga_rvalid   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_acc && !cpu_wren;
      cpu_err    <= cpu_acc && !cpu_in_range;
      if (cpu_acc && !cpu_wren)
        out_data_cpu <= cpu_in_range ? mem[cpu_idx] : '0;
      vga_rvalid <= vga_rd;
      if (vga_rd)
        out_data_vga <= vga_in_range ? mem[vga_idx][{vga_lane, 3'b000} +: PIX_W] : '0;
    end
  end

endmodule

// File: doc/data_mem_banked.md
Name: data_mem_banked

Overview:
Parametrised successor to the three-block CPU/VGA data memory. NUM_BANKS banks of word storage with a CPU read/write port (word address, byte enables, ready/valid handshake, range error) and an independent VGA byte-read port (byte address, never stalled). Adds a hardware bank-clear engine that zero-fills one bank, one word per cycle. Sits between the CPU load/store unit and the VGA frame fetcher.

Parameters:
NUM_BANKS, 3, number of banks
BANK_AW, 14, word-address bits per bank (2^BANK_AW words per bank)
DATA_W, 32, CPU word width; must be a multiple of 8
PIX_W, 8, VGA read width; fixed at 8 (byte lanes = DATA_W/8)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request
cpu_wren  in  1  1 = write, 0 = read
cpu_be  in  DATA_W/8  byte enables for writes; bit i selects bits 8i+7:8i
cpu_addr  in  32  word address; bank = cpu_addr / 2^BANK_AW
data_cpu  in  DATA_W  write data
cpu_ready  out  1  access accepted when cpu_req && cpu_ready
out_data_cpu  out  DATA_W  read data
cpu_rvalid  out  1  one-cycle pulse, out_data_cpu valid
cpu_err  out  1  one-cycle pulse, accepted access was out of range
vga_rd  in  1  VGA read strobe
vga_addr  in  32  byte address; word = vga_addr >> log2(DATA_W/8)
out_data_vga  out  PIX_W  read byte
vga_rvalid  out  1  one-cycle pulse, out_data_vga valid
clr_start  in  1  start clear of bank clr_bank
clr_bank  in  $clog2(NUM_BANKS) (min 1)  bank to clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse after last word cleared

Behaviour:
- Reset (async, rst_n=0): out_data_cpu=0, cpu_rvalid=0, cpu_err=0, out_data_vga=0, vga_rvalid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0. Array contents not reset.
- In range: word address < NUM_BANKS*2^BANK_AW.
- cpu_ready = (FSM==IDLE), combinational from state; 1 out of reset.
- CPU write accepted at edge E: enabled bytes updated at E; disabled bytes unchanged; cpu_be=0 is a legal no-op.
- CPU read accepted at E: out_data_cpu and cpu_rvalid=1 in cycle after E; out_data_cpu holds last value otherwise.
- Out-of-range access: write dropped; read returns 0 with cpu_rvalid=1; cpu_err=1 in cycle after E for both.
- VGA read at E: byte lane = vga_addr low log2(DATA_W/8) bits, little-endian (lane 0 = bits 7:0); out_data_vga/vga_rvalid in cycle after E; out of range returns 0x00, no error output. VGA is never stalled, including during clear (may see a partially cleared bank).
- Same-edge VGA read of a word being written (CPU or clear): old data returned (read-before-write).
- FSM IDLE -> CLEAR: clr_start=1 in IDLE with clr_bank < NUM_BANKS; latch bank, counter=0. clr_bank >= NUM_BANKS or clr_start while busy: ignored.
- CLEAR: each edge writes 0 to word counter of latched bank, counter+1. Edge writing word 2^BANK_AW-1 -> IDLE, clr_done=1 for the next cycle. clr_busy = (FSM==CLEAR); clear of 2^BANK_AW words takes exactly 2^BANK_AW cycles of clr_busy.
- clr_start and accepted cpu_req in same IDLE cycle: CPU access completes at that edge; clear then runs and overwrites it if in the cleared bank.
- cpu_req while busy: not accepted, held by requester; accepted first cycle after clr_busy falls.
- Reset mid-clear: abort to IDLE, words already cleared stay 0, remainder untouched, no clr_done.

Test Plan:
- Write data_cpu=0x00000001, be=4'b1111, cpu_addr=0; vga_rd at vga_addr=0 -> next cycle out_data_vga=0x01, vga_rvalid=1.
- Write 0xA1B2C3D4 at cpu_addr=16393; VGA reads 65572..65575 -> 0xD4,0xC3,0xB2,0xA1; CPU read 16393 -> 0xA1B2C3D4 with cpu_rvalid pulse; cpu_addr 32768 unchanged.
- 0x11223344 at 32768, then write 0xFFFFFFFF be=4'b0101 -> CPU read 0x11FF33FF.
- Write/read cpu_addr=49152 -> cpu_err pulses both times, read returns 0; vga_addr=196608 -> 0x00.
- BANK_AW=4: fill all 48 words nonzero; clr_start, clr_bank=1 -> clr_busy high 16 cycles, cpu_ready=0, held cpu_req accepted after; clr_done one pulse; bank 1 reads 0, banks 0/2 intact; clr_bank=3 ignored.
- BANK_AW=4: rst_n=0 after 8 clear cycles -> all outputs at reset values, bank 1 words 0..7 =0, 8..15 intact, no clr_done.
